// File: rtl/rail_sig_pkg.sv
// Shared types for the axle counter and the signalling stage it feeds.
package rail_sig_pkg;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    OCCUPIED = 2'd1,
    FAULT    = 2'd2
  } axle_state_t;

  // Aspect encoding consumed by the downstream signalling stage.
  typedef enum logic [1:0] {
    ASPECT_RED           = 2'b00,
    ASPECT_YELLOW        = 2'b01,
    ASPECT_DOUBLE_YELLOW = 2'b10,
    ASPECT_GREEN         = 2'b11
  } aspect_t;

endpackage

// File: rtl/sensor_debounce.sv
// Treadle conditioning: 2-FF synchroniser, debouncer and one-cycle rising-edge event.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [7:0] RUN_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       meta;
  logic       sync;
  logic [1:0] valid;
  logic       armed;
  logic       level_q;
  logic [7:0] run;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      valid <= 2'b00;
    end else begin
      meta  <= raw;
      sync  <= meta;
      valid <= {valid[0], 1'b1};
    end
  end

  // Until a debounced low has been seen after reset the sensor stays disarmed,
  // so a wheel parked on the treadle at power-up cannot count as an axle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      level   <= 1'b0;
      level_q <= 1'b0;
      armed   <= 1'b0;
      run     <= '0;
    end else begin
      level_q <= level;
      if (!valid[1]) begin
        run <= '0;
      end else if (!armed) begin
        if (sync) begin
          run <= '0;
        end else if (run == RUN_LAST) begin
          armed <= 1'b1;
          run   <= '0;
        end else begin
          run <= run + 8'd1;
        end
      end else if (sync != level) begin
        if (run == RUN_LAST) begin
          level <= sync;
          run   <= '0;
        end else begin
          run <= run + 8'd1;
        end
      end else begin
        run <= '0;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/track_section_axle_counter.sv
// Block-section axle counter producing the occupancy input x; fails safe to occupied.
// Optional occupancy supervision timeout enabled by defining AXLE_TIMEOUT_EN.
module track_section_axle_counter
  import rail_sig_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             s_in,
  input  logic             s_out,
  input  logic             sec_rst,
  output logic             x,
  output logic [CNT_W-1:0] axle_count,
  output logic             fault
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  axle_state_t      state;
  axle_state_t      state_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             lvl_in;
  logic             lvl_out;
  logic             ev_in;
  logic             ev_out;
  logic             inc;
  logic             dec;
  logic             idle;
  logic             timeout_hit;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 || CNT_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("track_section_axle_counter: parameter out of range");
  end

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_in (
    .clk   (clk),
    .clr   (clr),
    .raw   (s_in),
    .level (lvl_in),
    .rise  (ev_in)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_out (
    .clk   (clk),
    .clr   (clr),
    .raw   (s_out),
    .level (lvl_out),
    .rise  (ev_out)
  );

  assign inc  = ev_in & ~ev_out;
  assign dec  = ev_out & ~ev_in;
  assign idle = ~lvl_in & ~lvl_out;

`ifdef AXLE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      timer <= '0;
    end else if (state != OCCUPIED || ev_in || ev_out) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign timeout_hit = (state == OCCUPIED) && !(ev_in || ev_out) && (timer == TMR_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= CLEAR;
      axle_count <= '0;
    end else begin
      state      <= state_nxt;
      axle_count <= count_nxt;
    end
  end

  // In FAULT the count keeps moving, saturating, purely as a diagnostic aid.
  always_comb begin
    state_nxt = state;
    count_nxt = axle_count;
    case (state)
      CLEAR: begin
        if (inc) begin
          state_nxt = OCCUPIED;
          count_nxt = CNT_W'(1);
        end else if (dec) begin
          state_nxt = FAULT;
        end
      end
      OCCUPIED: begin
        if (inc) begin
          if (axle_count == CNT_MAX) state_nxt = FAULT;
          else                       count_nxt = axle_count + 1'b1;
        end else if (dec) begin
          count_nxt = axle_count - 1'b1;
          if (axle_count == CNT_W'(1)) state_nxt = CLEAR;
        end else if (timeout_hit) begin
          state_nxt = FAULT;
        end
      end
      FAULT: begin
        if (sec_rst && idle) begin
          state_nxt = CLEAR;
          count_nxt = '0;
        end else if (inc && axle_count != CNT_MAX) begin
          count_nxt = axle_count + 1'b1;
        end else if (dec && axle_count != '0) begin
          count_nxt = axle_count - 1'b1;
        end
      end
      default: begin
        state_nxt = CLEAR;
        count_nxt = '0;
      end
    endcase
  end

  assign x     = (state != CLEAR);
  assign fault = (state == FAULT);

endmodule

// File: tb/tb_track_section_axle_counter.sv
// Self-checking bench for track_section_axle_counter: directed runs plus random treadle traffic
// compared against a timeline model built from the sensor waveforms.
module tb_track_section_axle_counter;

  localparam int D      = 4;
  localparam int CW     = 4;
  localparam int TO     = 50;
  localparam int MAXN   = 700;
  localparam int CMAX   = (1 << CW) - 1;
  localparam int ST_CLR = 0;
  localparam int ST_OCC = 1;
  localparam int ST_FLT = 2;
`ifdef AXLE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          s_in = 1'b0;
  logic          s_out = 1'b0;
  logic          sec_rst = 1'b0;
  logic          x;
  logic          fault;
  logic [CW-1:0] axle_count;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  bit raw  [2][MAXN];
  bit lvl  [2][MAXN];
  bit srst [MAXN];
  int run_len;
  int abort_at;
  int m_st;
  int m_cnt;
  int m_age;

  always #5 clk = ~clk;

  track_section_axle_counter #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .s_in       (s_in),
    .s_out      (s_out),
    .sec_rst    (sec_rst),
    .x          (x),
    .axle_count (axle_count),
    .fault      (fault)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clear_sched(input int len);
    run_len  = len;
    abort_at = 0;
    for (int e = 0; e < MAXN; e++) begin
      raw[0][e] = 1'b0;
      raw[1][e] = 1'b0;
      srst[e]   = 1'b0;
    end
  endtask

  task automatic add_pulse(input int s, input int start, input int len);
    for (int k = start; k < start + len && k < MAXN; k++) raw[s][k] = 1'b1;
  endtask

  // A high run counts as an axle only if it lasts D samples and follows at least D
  // low samples; the debounced level then holds from start+D+1 to end+D edges.
  task automatic derive_levels();
    int lows, t, h, e;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < MAXN; k++) lvl[s][k] = 1'b0;
      lows = 0;
      e = 1;
      while (e <= run_len) begin
        if (!raw[s][e]) begin
          lows++;
          e++;
        end else begin
          t = e;
          while (e <= run_len && raw[s][e]) e++;
          h = e - t;
          if (h >= D && lows >= D)
            for (int k = t + D + 1; k <= t + h + D && k <= run_len; k++) lvl[s][k] = 1'b1;
          lows = 0;
        end
      end
    end
  endtask

  task automatic model_step(input int e);
    bit ei, eo, inc, dec, idle;
    ei   = (e >= 2) ? (lvl[0][e-1] && !lvl[0][e-2]) : 1'b0;
    eo   = (e >= 2) ? (lvl[1][e-1] && !lvl[1][e-2]) : 1'b0;
    inc  = ei && !eo;
    dec  = eo && !ei;
    idle = !lvl[0][e-1] && !lvl[1][e-1];
    case (m_st)
      ST_CLR: begin
        if (inc) begin
          m_st  = ST_OCC;
          m_cnt = 1;
          m_age = 0;
        end else if (dec) begin
          m_st = ST_FLT;
        end
      end
      ST_OCC: begin
        if (ei || eo) begin
          m_age = 0;
          if (inc) begin
            if (m_cnt == CMAX) m_st = ST_FLT;
            else m_cnt++;
          end else if (dec) begin
            m_cnt--;
            if (m_cnt == 0) m_st = ST_CLR;
          end
        end else begin
          m_age++;
          if (TO_EN && m_age == TO) m_st = ST_FLT;
        end
      end
      default: begin
        if (srst[e] && idle) begin
          m_st  = ST_CLR;
          m_cnt = 0;
        end else if (inc && m_cnt < CMAX) begin
          m_cnt++;
        end else if (dec && m_cnt > 0) begin
          m_cnt--;
        end
      end
    endcase
  endtask

  task automatic apply_stimulus(input string name);
    derive_levels();
    clr     = 1'b0;
    s_in    = raw[0][1];
    s_out   = raw[1][1];
    sec_rst = 1'b0;
    @(negedge clk);
    #1;
    check_output({name, ":rst_count"}, axle_count, 0);
    check_output({name, ":rst_x"}, x, 0);
    check_output({name, ":rst_fault"}, fault, 0);
    m_st  = ST_CLR;
    m_cnt = 0;
    m_age = 0;
    @(negedge clk);
    clr = 1'b1;
    for (int e = 1; e <= run_len; e++) begin
      s_in    = raw[0][e];
      s_out   = raw[1][e];
      sec_rst = srst[e];
      @(posedge clk);
      #1;
      model_step(e);
      check_output($sformatf("%s:count@%0d", name, e), axle_count, m_cnt);
      check_output($sformatf("%s:x@%0d", name, e), x, m_st != ST_CLR);
      check_output($sformatf("%s:fault@%0d", name, e), fault, m_st == ST_FLT);
      if (e == abort_at) begin
        #2;
        clr = 1'b0;
        #1;
        check_output({name, ":abort_count"}, axle_count, 0);
        check_output({name, ":abort_x"}, x, 0);
        check_output({name, ":abort_fault"}, fault, 0);
        break;
      end
    end
    s_in    = 1'b0;
    s_out   = 1'b0;
    sec_rst = 1'b0;
  endtask

  task automatic build_random(input int len);
    int pos;
    clear_sched(len);
    for (int s = 0; s < 2; s++) begin
      pos = 9 + $urandom_range(0, 10);
      while (pos < len - 40) begin
        int h;
        h = $urandom_range(1, 2 * D + 6);
        add_pulse(s, pos, h);
        pos += h + $urandom_range(D + 1, 16);
      end
    end
    for (int e = 1; e < len; e++) srst[e] = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    $display("[TB] clean single axle");
    clear_sched(70);
    add_pulse(0, 10, 10);
    add_pulse(1, 40, 10);
    apply_stimulus("single");

    $display("[TB] glitch rejection");
    clear_sched(30);
    add_pulse(0, 10, 3);
    apply_stimulus("glitch");

    $display("[TB] four-axle train");
    clear_sched(160);
    for (int k = 0; k < 4; k++) add_pulse(0, 10 + 16 * k, 8);
    for (int k = 0; k < 4; k++) add_pulse(1, 80 + 16 * k, 8);
    apply_stimulus("train4");

    $display("[TB] simultaneous events");
    clear_sched(80);
    add_pulse(0, 10, 8);
    add_pulse(0, 26, 8);
    add_pulse(0, 50, 8);
    add_pulse(1, 50, 8);
    apply_stimulus("simul");

    $display("[TB] underflow and section reset");
    clear_sched(80);
    add_pulse(1, 10, 8);
    add_pulse(0, 30, 20);
    srst[40] = 1'b1;
    srst[70] = 1'b1;
    apply_stimulus("underflow");

    $display("[TB] sensor held through reset release");
    clear_sched(60);
    add_pulse(0, 1, 20);
    add_pulse(0, 35, 8);
    apply_stimulus("held");

    $display("[TB] overflow");
    clear_sched(300);
    for (int k = 0; k <= CMAX; k++) add_pulse(0, 10 + 16 * k, 8);
    srst[280] = 1'b1;
    apply_stimulus("overflow");

    $display("[TB] mid-train reset");
    clear_sched(80);
    for (int k = 0; k < 3; k++) add_pulse(0, 10 + 16 * k, 8);
    abort_at = 60;
    apply_stimulus("midreset");

    $display("[TB] stalled train");
    clear_sched(100);
    add_pulse(0, 10, 8);
    apply_stimulus("stall");

    for (int r = 0; r < 5; r++) begin
      $display("[TB] random traffic run %0d", r);
      build_random(600);
      apply_stimulus($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/track_section_axle_counter.md
# track_section_axle_counter

Axle-counting track-circuit block that sits directly upstream of the automatic signalling stage and produces its train-presence input `x`. It conditions the raw entry and exit treadle sensors of one block section and counts axles in and out. It declares the section occupied while any axle remains inside, and fails safe (occupied) on any counting anomaly.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required before a sensor level change is accepted (range 2–255).
- `CNT_W`, default 8: axle counter width.
- `TIMEOUT_CYCLES`, default 1000: occupancy supervision limit; used only with `AXLE_TIMEOUT_EN`.
- `clk` in 1: system clock; all state changes on its rising edge.
- `clr` in 1: reset, asynchronous, active-low.
- `s_in` in 1: raw entry treadle; high while a wheel is over it; asynchronous to `clk`.
- `s_out` in 1: raw exit treadle; same electrical behaviour as `s_in`.
- `sec_rst` in 1: section-reset request pulse from the operator, synchronous to `clk`.
- `x` out 1: section occupied. Feeds the signalling stage.
- `axle_count` out CNT_W: axles currently inside the section.
- `fault` out 1: counting anomaly latched.

## Operation
- Each sensor passes through a 2-FF synchroniser, then a debouncer.
  - The debounced level changes only after the synchronised level has differed from it for `DEBOUNCE_CYCLES` consecutive samples.
  - Any intervening mismatch-free sample restarts the count.
- An axle event is a debounced 0→1 transition, one cycle wide: `ev_in` or `ev_out`.
- Counter update, evaluated per cycle:
  - `ev_in` only: +1.
  - `ev_out` only: −1.
  - Both, or neither: unchanged.
- FSM states: `CLEAR`, `OCCUPIED`, `FAULT`.
  - `CLEAR`→`OCCUPIED` on `ev_in` without `ev_out`.
  - `CLEAR`→`FAULT` on `ev_out` without `ev_in` (underflow). Count stays 0.
  - `OCCUPIED`→`CLEAR` when the count decrements to 0.
  - `OCCUPIED`→`FAULT` on `ev_in` at count = 2^CNT_W−1 (overflow). Count saturates.
  - `FAULT`→`CLEAR` only when `sec_rst`=1 and both debounced sensors are 0. This also zeroes the count. `sec_rst` is ignored in other states and when either sensor is active.
  - In `FAULT`, events still update the count with saturation at both ends, giving diagnostics only.
- Outputs:
  - `x` = 1 in `OCCUPIED` and `FAULT`, 0 in `CLEAR`. The block is fail-safe: a fault always shows occupied.
  - `fault` = 1 only in `FAULT`.
- Reset (asserted at any time, including mid-train) forces:
  - state `CLEAR`, `axle_count`=0, `x`=0, `fault`=0;
  - synchronisers and debounced levels to 0, debounce counters to 0.
- A sensor held high through reset release produces no event until it has been seen low and debounced.

## Timing
- Latency from the first `clk` edge sampling a new stable raw level to the `axle_count`/`x` update is `DEBOUNCE_CYCLES`+3 edges:
  - 2 edges in the synchroniser;
  - `DEBOUNCE_CYCLES` edges in the debouncer;
  - 1 edge for the event-to-register update.
- Outputs are registered; no combinational path from inputs to outputs.
- Pulses shorter than `DEBOUNCE_CYCLES` cycles after synchronisation are rejected.
- `sec_rst` takes effect at the edge it is sampled high. The state is `CLEAR` with `x`=0 on the following cycle.

## Configuration
- `AXLE_TIMEOUT_EN` defined: adds occupancy supervision.
  - A counter runs while in `OCCUPIED` and restarts on any axle event.
  - Reaching `TIMEOUT_CYCLES` moves the FSM to `FAULT` (train stalled or sensor dead).
  - The counter resets on leaving `OCCUPIED`.
- `AXLE_TIMEOUT_EN` undefined: no timeout logic. `OCCUPIED` persists indefinitely and `TIMEOUT_CYCLES` is unused.

## Structure
- Shared package `rail_sig_pkg`: state enum `axle_state_t` {`CLEAR`, `OCCUPIED`, `FAULT`}, and the 2-bit signal aspect encoding shared with the signalling stage.
- Sub-module `sensor_debounce`: synchroniser, debouncer and rising-edge event output, parameterised by `DEBOUNCE_CYCLES`. Instantiated twice.
- Top level: counter, FSM and optional timeout.

## Test plan
- Reset, then one clean axle: `s_in` high for 10 cycles then low, later `s_out` the same.
  - Required: `axle_count` 0→1, `x`=1, 7 edges after `s_in` rises (`DEBOUNCE_CYCLES`=4).
  - Then back to 0, `x`=0, after the `s_out` pulse.
- Glitch rejection: `s_in` high for 3 cycles → `axle_count` stays 0, `x` stays 0.
- Four-axle train: 4 `s_in` pulses (8 high / 8 low each), then 4 `s_out` pulses.
  - Required: count steps 1,2,3,4, then 3,2,1,0; `x` falls only at 0.
- Simultaneous events: with count=2, `s_in` and `s_out` pulses aligned → count stays 2, no state change.
- Underflow and recovery: from reset, one `s_out` pulse → `fault`=1, `x`=1, count 0.
  - `sec_rst` while `s_in` is high → ignored.
  - `sec_rst` with both sensors idle → `fault`=0, `x`=0 next cycle.
- Mid-train reset, and timeout with `AXLE_TIMEOUT_EN` and `TIMEOUT_CYCLES`=50:
  - Assert `clr` at count 3 → all outputs 0 immediately.
  - Separately, one `s_in` pulse with no further events → `fault`=1 exactly 50 cycles after the count update.
